// File: rtl/lcd_pkg.sv
// Shared constants for the ILI9488 power-up sequencer: table entry layout,
// opcodes and FSM state encoding.
package lcd_pkg;

  localparam int ENTRY_W = 10;

  typedef struct packed {
    logic [1:0] op;
    logic [7:0] arg;
  } entry_t;

  localparam logic [1:0] OP_CMD   = 2'b00;
  localparam logic [1:0] OP_DATA  = 2'b01;
  localparam logic [1:0] OP_DELAY = 2'b10;
  localparam logic [1:0] OP_END   = 2'b11;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_HW_RST   = 3'd1;
  localparam logic [2:0] ST_POR_WAIT = 3'd2;
  localparam logic [2:0] ST_FETCH    = 3'd3;
  localparam logic [2:0] ST_SEND     = 3'd4;
  localparam logic [2:0] ST_DELAY    = 3'd5;
  localparam logic [2:0] ST_DONE     = 3'd6;

endpackage

// File: rtl/lcd_init_rom.sv
// Combinational init table: ILI9488 bring-up sequence, or a caller-supplied
// flat table when USE_TEST_TABLE is set.
module lcd_init_rom
  import lcd_pkg::*;
#(
  parameter int ROM_AW = 6,
  parameter bit USE_TEST_TABLE = 1'b0,
  parameter logic [(2**ROM_AW)*ENTRY_W-1:0] TEST_TABLE = '0
) (
  input  logic [ROM_AW-1:0]  i_addr,
  output logic [ENTRY_W-1:0] o_entry
);

  logic [ENTRY_W-1:0] w_tab [2**ROM_AW];
  logic [31:0]        w_idx;

  for (genvar g = 0; g < 2**ROM_AW; g++) begin : g_unpack
    assign w_tab[g] = TEST_TABLE[g*ENTRY_W +: ENTRY_W];
  end

  assign w_idx = 32'(i_addr);

  // Table lookup; unlisted addresses read as END
  always_comb begin
    o_entry = {OP_END, 8'h00};
    if (USE_TEST_TABLE) begin
      o_entry = w_tab[i_addr];
    end else begin
      case (w_idx)
        32'd0:   o_entry = {OP_CMD,   8'h01};
        32'd1:   o_entry = {OP_DELAY, 8'd5};
        32'd2:   o_entry = {OP_CMD,   8'h11};
        32'd3:   o_entry = {OP_DELAY, 8'd120};
        32'd4:   o_entry = {OP_CMD,   8'h3A};
        32'd5:   o_entry = {OP_DATA,  8'h55};
        32'd6:   o_entry = {OP_CMD,   8'h36};
        32'd7:   o_entry = {OP_DATA,  8'h48};
        32'd8:   o_entry = {OP_CMD,   8'h29};
        default: o_entry = {OP_END,   8'h00};
      endcase
    end
  end

endmodule

// File: rtl/lcd_init_sequencer.sv
// ILI9488 power-up sequencer: hardware reset, power-on wait, then walks the
// init table, offering each byte on a valid/ready handshake.
module lcd_init_sequencer
  import lcd_pkg::*;
#(
  parameter int TICK_DIV    = 50000,
  parameter int RST_LOW_MS  = 10,
  parameter int POR_WAIT_MS = 120,
  parameter int ROM_AW      = 6,
  parameter bit USE_TEST_TABLE = 1'b0,
  parameter logic [(2**ROM_AW)*ENTRY_W-1:0] TEST_TABLE = '0
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       lcd_rst_n,
  output logic       wr_valid,
  input  logic       wr_ready,
  output logic       wr_dc,
  output logic [7:0] wr_data
);

  localparam int MAX_UNITS_A = (RST_LOW_MS > POR_WAIT_MS) ? RST_LOW_MS : POR_WAIT_MS;
  localparam int MAX_UNITS   = (MAX_UNITS_A > 255) ? MAX_UNITS_A : 255;
  localparam int CNT_W       = $clog2(MAX_UNITS * TICK_DIV + 1);
  localparam logic [CNT_W-1:0] RST_LOAD = CNT_W'(RST_LOW_MS * TICK_DIV - 1);
  localparam logic [CNT_W-1:0] POR_LOAD = CNT_W'(POR_WAIT_MS * TICK_DIV - 1);

  logic [2:0]         r_state;
  logic [2:0]         w_next_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_load;
  logic [CNT_W-1:0]   w_delay_load;
  logic [ROM_AW-1:0]  r_ptr;
  logic               w_ptr_inc;
  logic               w_ptr_clr;
  logic [ENTRY_W-1:0] w_entry;
  logic [1:0]         w_op;
  logic [7:0]         w_arg;
  logic               w_is_last;
  logic               r_busy;
  logic               r_done;
  logic               r_lcd_rst_n;
  logic               r_wr_valid;
  logic               r_wr_dc;
  logic [7:0]         r_wr_data;

  lcd_init_rom #(
    .ROM_AW         (ROM_AW),
    .USE_TEST_TABLE (USE_TEST_TABLE),
    .TEST_TABLE     (TEST_TABLE)
  ) u_rom (
    .i_addr  (r_ptr),
    .o_entry (w_entry)
  );

  assign w_op      = w_entry[9:8];
  assign w_arg     = w_entry[7:0];
  assign w_is_last = &r_ptr;
  // Counter runs load..0 inclusive, so a delay of N cycles loads N-1
  assign w_delay_load = (w_arg == 8'd0) ? '0 : CNT_W'(int'(w_arg) * TICK_DIV - 1);

  // Next-state, counter reload value and pointer control
  always_comb begin
    w_next_state = r_state;
    w_cnt_load   = '0;
    w_ptr_inc    = 1'b0;
    w_ptr_clr    = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_next_state = ST_HW_RST;
          w_cnt_load   = RST_LOAD;
          w_ptr_clr    = 1'b1;
        end else begin
          w_next_state = r_state;
        end
      end
      ST_HW_RST: begin
        if (r_cnt == '0) begin
          w_next_state = ST_POR_WAIT;
          w_cnt_load   = POR_LOAD;
        end else begin
          w_next_state = ST_HW_RST;
        end
      end
      ST_POR_WAIT: begin
        if (r_cnt == '0) begin
          w_next_state = ST_FETCH;
        end else begin
          w_next_state = ST_POR_WAIT;
        end
      end
      ST_FETCH: begin
        // The top table slot always terminates, even without an END entry
        if (w_is_last || (w_op == OP_END)) begin
          w_next_state = ST_DONE;
        end else if (w_op == OP_DELAY) begin
          w_next_state = ST_DELAY;
          w_cnt_load   = w_delay_load;
        end else begin
          w_next_state = ST_SEND;
        end
      end
      ST_SEND: begin
        if (r_wr_valid && wr_ready) begin
          w_next_state = ST_FETCH;
          w_ptr_inc    = 1'b1;
        end else begin
          w_next_state = ST_SEND;
        end
      end
      ST_DELAY: begin
        if (r_cnt == '0) begin
          w_next_state = ST_FETCH;
          w_ptr_inc    = 1'b1;
        end else begin
          w_next_state = ST_DELAY;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Delay down-counter, reloaded on every state change
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_next_state != r_state) begin
      r_cnt <= w_cnt_load;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  // Table pointer
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_ptr_clr) begin
      r_ptr <= '0;
    end else if (w_ptr_inc) begin
      r_ptr <= r_ptr + ROM_AW'(1);
    end
  end

  // Registered outputs decoded from the next state
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_lcd_rst_n <= 1'b1;
      r_wr_valid  <= 1'b0;
      r_wr_dc     <= 1'b0;
      r_wr_data   <= 8'h00;
    end else begin
      r_busy      <= (w_next_state != ST_IDLE) && (w_next_state != ST_DONE);
      r_done      <= (w_next_state == ST_DONE);
      r_lcd_rst_n <= (w_next_state != ST_HW_RST);
      r_wr_valid  <= (w_next_state == ST_SEND);
      if ((r_state == ST_FETCH) && (w_next_state == ST_SEND)) begin
        r_wr_dc   <= w_op[0];
        r_wr_data <= w_arg;
      end
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign lcd_rst_n = r_lcd_rst_n;
  assign wr_valid  = r_wr_valid;
  assign wr_dc     = r_wr_dc;
  assign wr_data   = r_wr_data;

endmodule

// File: tb/tb_lcd_init_sequencer.sv
// Bench for lcd_init_sequencer: two instances with small test tables, a
// timeline model of the table walk, vector table plus randomized runs.
`timescale 1ns/1ps
module tb_lcd_init_sequencer;

  localparam int TICK  = 4;
  localparam int RSTMS = 2;
  localparam int PORMS = 3;

  // A: DELAY 0, CMD 29, CMD 3A, DATA 55, CMD 11, DELAY 3, CMD 29, END
  localparam logic [159:0] TAB_A = {{8{10'h300}}, 10'h300, 10'h029, 10'h203, 10'h011,
                                    10'h155, 10'h03A, 10'h029, 10'h200};
  // B: four commands and no END, so the top slot must act as END
  localparam logic [39:0] TAB_B = {10'h0A3, 10'h0A2, 10'h0A1, 10'h0A0};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic start_a = 1'b0, start_b = 1'b0, ready_a = 1'b0, ready_b = 1'b0;
  logic busy_a, done_a, lrn_a, val_a, dc_a;
  logic busy_b, done_b, lrn_b, val_b, dc_b;
  logic [7:0] data_a, data_b;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  typedef struct {int dc; int data; int offer; int hs;} xfer_t;
  xfer_t exp_q[$];
  int exp_done;

  typedef struct {int sel; int st0; int st1; int st2; int st3; int st4; int poke; int exp_done;} vec_t;
  vec_t vecs[5];

  lcd_init_sequencer #(.TICK_DIV(TICK), .RST_LOW_MS(RSTMS), .POR_WAIT_MS(PORMS),
    .ROM_AW(4), .USE_TEST_TABLE(1'b1), .TEST_TABLE(TAB_A)) dut_a (
    .clk_in(clk), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a),
    .lcd_rst_n(lrn_a), .wr_valid(val_a), .wr_ready(ready_a), .wr_dc(dc_a), .wr_data(data_a));

  lcd_init_sequencer #(.TICK_DIV(TICK), .RST_LOW_MS(RSTMS), .POR_WAIT_MS(PORMS),
    .ROM_AW(2), .USE_TEST_TABLE(1'b1), .TEST_TABLE(TAB_B)) dut_b (
    .clk_in(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b),
    .lcd_rst_n(lrn_b), .wr_valid(val_b), .wr_ready(ready_b), .wr_dc(dc_b), .wr_data(data_b));

  task automatic check1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %b expected %b", name, cyc, act, exp);
    end
  endtask

  task automatic checkn(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // Timeline relative to the edge that captures start: reset + POR, then
  // per entry FETCH(1) + SEND(1+stall) or FETCH(1) + max(1, arg*TICK).
  function automatic void build_model(input int sel, input int st[8]);
    logic [159:0] tab;
    int n, t, k, op, arg;
    tab = (sel == 0) ? TAB_A : 160'(TAB_B);
    n   = (sel == 0) ? 16 : 4;
    exp_q.delete();
    t = (RSTMS + PORMS) * TICK;
    k = 0;
    exp_done = t + 1;
    for (int i = 0; i < n; i++) begin
      op  = int'(tab[i*10+8 +: 2]);
      arg = int'(tab[i*10 +: 8]);
      if (op == 3 || i == n - 1) begin
        exp_done = t + 1;
        break;
      end
      if (op < 2) begin
        xfer_t x;
        x.dc = op % 2;
        x.data = arg;
        x.offer = t + 1;
        x.hs = t + 2 + st[k];
        exp_q.push_back(x);
        t = x.hs;
        k++;
      end else begin
        t = t + 1 + ((arg == 0) ? 1 : arg * TICK);
      end
    end
  endfunction

  task automatic drive(input int sel, input logic s, input logic r);
    start_a = (sel == 0) ? s : 1'b0;
    start_b = (sel == 1) ? s : 1'b0;
    ready_a = (sel == 0) ? r : 1'b0;
    ready_b = (sel == 1) ? r : 1'b0;
  endtask

  task automatic run(input int sel, input int st[8], input int poke, input int abort_rc,
                     input int done_fix);
    int s_edge, rc, k, first_done, hs_seen;
    logic b, d, l, v, dc, rdy, vexp;
    logic [7:0] dat;
    build_model(sel, st);
    @(negedge clk);
    drive(sel, 1'b1, 1'b0);
    s_edge = cyc + 1;
    k = 0;
    first_done = -1;
    hs_seen = 0;
    for (int n = 0; n < exp_done + 4; n++) begin
      @(negedge clk);
      rc = cyc - s_edge;
      b   = (sel == 0) ? busy_a : busy_b;
      d   = (sel == 0) ? done_a : done_b;
      l   = (sel == 0) ? lrn_a  : lrn_b;
      v   = (sel == 0) ? val_a  : val_b;
      dc  = (sel == 0) ? dc_a   : dc_b;
      dat = (sel == 0) ? data_a : data_b;
      if (k < exp_q.size() && rc >= exp_q[k].hs) k++;
      vexp = (k < exp_q.size()) && (rc >= exp_q[k].offer);
      check1("lcd_rst_n", l, !(rc >= 0 && rc < RSTMS * TICK));
      check1("busy", b, rc < exp_done);
      check1("done", d, rc >= exp_done);
      check1("wr_valid", v, vexp);
      if (vexp) begin
        checkn("wr_dc", 32'(dc), exp_q[k].dc);
        checkn("wr_data", 32'(dat), exp_q[k].data);
      end
      if (rc == abort_rc) begin
        rst = 1'b1;
        drive(sel, 1'b0, 1'b0);
        #1;
        check1("rst_valid", (sel == 0) ? val_a : val_b, 1'b0);
        check1("rst_busy", (sel == 0) ? busy_a : busy_b, 1'b0);
        check1("rst_done", (sel == 0) ? done_a : done_b, 1'b0);
        check1("rst_lcd_rst_n", (sel == 0) ? lrn_a : lrn_b, 1'b1);
        check1("rst_dc", (sel == 0) ? dc_a : dc_b, 1'b0);
        checkn("rst_data", 32'((sel == 0) ? data_a : data_b), 32'd0);
        return;
      end
      rdy = vexp ? (rc + 1 == exp_q[k].hs) : 1'($urandom_range(0, 1));
      if (v === 1'b1 && rdy) hs_seen++;
      drive(sel, (rc + 1 == poke), rdy);
      if (d === 1'b1 && first_done < 0) first_done = rc;
    end
    checkn("handshakes", hs_seen, exp_q.size());
    if (done_fix >= 0) checkn("done_cycle", first_done, done_fix);
  endtask

  initial begin
    int st[8];
    vecs[0] = '{0, 0, 0, 0, 0, 0, -1, 46};
    vecs[1] = '{0, 0, 5, 0, 0, 0, -1, 51};
    vecs[2] = '{0, 0, 0, 0, 0, 0, 30, 46};
    vecs[3] = '{1, 0, 0, 0, 0, 0, -1, 27};
    vecs[4] = '{1, 2, 0, 0, 0, 0, 12, 29};

    repeat (3) @(negedge clk);
    check1("reset_busy", busy_a, 1'b0);
    check1("reset_done", done_a, 1'b0);
    check1("reset_lcd_rst_n", lrn_a, 1'b1);
    check1("reset_valid", val_a, 1'b0);
    check1("reset_dc", dc_a, 1'b0);
    checkn("reset_data", 32'(data_a), 32'd0);
    check1("reset_valid_b", val_b, 1'b0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      st = '{vecs[i].st0, vecs[i].st1, vecs[i].st2, vecs[i].st3, vecs[i].st4, 0, 0, 0};
      run(vecs[i].sel, st, vecs[i].poke, -1, vecs[i].exp_done);
    end

    for (int r = 0; r < 6; r++) begin
      int sel, poke;
      sel = int'($urandom_range(0, 1));
      for (int j = 0; j < 8; j++) st[j] = int'($urandom_range(0, 4));
      poke = ($urandom_range(0, 1) == 1) ? int'($urandom_range(10, 20)) : -1;
      run(sel, st, poke, -1, -1);
    end

    // Reset while 0x3A is stalled on the bus, then a clean replay
    st = '{0, 4, 0, 0, 0, 0, 0, 0};
    run(0, st, -1, 27, -1);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check1("idle_busy", busy_a, 1'b0);
      check1("idle_valid", val_a, 1'b0);
      check1("idle_lcd_rst_n", lrn_a, 1'b1);
    end
    st = '{0, 0, 0, 0, 0, 0, 0, 0};
    run(0, st, -1, -1, 46);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, bad=%0d", bad);
    $fatal(1);
  end

endmodule
